// File: rtl/mbssoc_bus_timer_pkg.sv
// Shared constants for the memory-mapped bus timer: register offsets,
// CTRL field layout and bus FSM encodings.
package mbssoc_bus_timer_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_LOAD   = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN          = 0;
  localparam int CTRL_AUTO_RELOAD = 1;
  localparam int CTRL_IE          = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RESP = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  typedef struct packed {
    logic ie;
    logic auto_reload;
    logic en;
  } ctrl_t;

  // Exactly one strobe; both set together is a protocol error and is ignored.
  function automatic logic is_single_op(input logic re, input logic we);
    return re ^ we;
  endfunction

endpackage

// File: rtl/mbssoc_timer_core.sv
// Prescaler, countdown counter and sticky expiry flag for the bus timer.
module mbssoc_timer_core
  import mbssoc_bus_timer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PRESCALE   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  auto_reload,
  input  logic                  start,
  input  logic                  exp_clr,
  input  logic [DATA_WIDTH-1:0] load_val,
  output logic [DATA_WIDTH-1:0] count,
  output logic                  expired,
  output logic                  oneshot_done
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre;
  logic             tick;
  logic             at_zero;

  assign tick         = en && (pre == PRE_MAX);
  assign at_zero      = (count == '0);
  assign oneshot_done = tick && at_zero && !auto_reload;

  always_ff @(posedge clk) begin
    if (rst) begin
      pre     <= '0;
      count   <= '0;
      expired <= 1'b0;
    end else begin
      if (start) begin
        pre   <= '0;
        count <= load_val;
      end else if (!en) begin
        pre <= '0;
      end else begin
        pre <= tick ? '0 : pre + PRE_W'(1);
        if (tick) begin
          if (!at_zero)
            count <= count - DATA_WIDTH'(1);
          else if (auto_reload)
            count <= load_val;
        end
      end
      // An expiry on the same cycle as a clear keeps the flag set.
      if (tick && at_zero)
        expired <= 1'b1;
      else if (exp_clr)
        expired <= 1'b0;
    end
  end

endmodule

// File: rtl/mbssoc_bus_timer.sv
// Bus responder for the countdown timer: 4-word register window, ack
// handshake FSM and registered level interrupt.
//
// state   | meaning
// IDLE    | waiting for a hit with a single strobe; write performed on accept
// RESP    | one-cycle ack, read data driven with rdata_oe
// HOLD    | waiting for both strobes to drop so a held strobe acks once
module mbssoc_bus_timer
  import mbssoc_bus_timer_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h0000_FF00),
  parameter int                    PRESCALE   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bus_re,
  input  logic                  bus_we,
  input  logic [ADDR_WIDTH-1:0] bus_addr,
  input  logic [DATA_WIDTH-1:0] bus_wdata,
  output logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  rdata_oe,
  output logic                  bus_ack,
  output logic                  irq
);

  logic [1:0]            state;
  ctrl_t                 ctrl;
  logic [DATA_WIDTH-1:0] load_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] count;
  logic [DATA_WIDTH-1:0] reg_rd;
  logic [1:0]            off;
  logic                  op_rd;
  logic                  irq_q;
  logic                  hit, accept, wr_en, start, exp_clr;
  logic                  expired, oneshot_done, resp;

  assign off     = bus_addr[1:0];
  assign hit     = (bus_addr[ADDR_WIDTH-1:2] == BASE_ADDR[ADDR_WIDTH-1:2]);
  assign accept  = (state == ST_IDLE) && hit && is_single_op(bus_re, bus_we);
  assign wr_en   = accept && bus_we;
  assign start   = wr_en && (off == REG_CTRL) && bus_wdata[CTRL_EN] && !ctrl.en;
  assign exp_clr = wr_en && (off == REG_STATUS) && bus_wdata[0];

  always_comb begin
    reg_rd = '0;
    case (off)
      REG_CTRL:   reg_rd = DATA_WIDTH'(ctrl);
      REG_LOAD:   reg_rd = load_q;
      REG_COUNT:  reg_rd = count;
      REG_STATUS: reg_rd = DATA_WIDTH'(expired);
      default:    reg_rd = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      op_rd   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          state   <= ST_RESP;
          op_rd   <= bus_re;
          rdata_q <= bus_re ? reg_rd : '0;
        end
        ST_RESP: state <= ST_HOLD;
        ST_HOLD: if (!bus_re && !bus_we) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl   <= '0;
      load_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (wr_en && (off == REG_CTRL))
        ctrl <= ctrl_t'(bus_wdata[CTRL_IE:CTRL_EN]);
      else if (oneshot_done)
        ctrl.en <= 1'b0;
      if (wr_en && (off == REG_LOAD))
        load_q <= bus_wdata;
      irq_q <= expired & ctrl.ie;
    end
  end

  mbssoc_timer_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .PRESCALE   (PRESCALE)
  ) u_core (
    .clk          (clk),
    .rst          (rst),
    .en           (ctrl.en),
    .auto_reload  (ctrl.auto_reload),
    .start        (start),
    .exp_clr      (exp_clr),
    .load_val     (load_q),
    .count        (count),
    .expired      (expired),
    .oneshot_done (oneshot_done)
  );

  // Reset landing on a RESP cycle must not let the ack escape.
  assign resp      = (state == ST_RESP) && !rst;
  assign bus_ack   = resp;
  assign rdata_oe  = resp && op_rd;
  assign bus_rdata = rdata_oe ? rdata_q : '0;
  assign irq       = irq_q;

endmodule

// File: tb/tb_mbssoc_bus_timer.sv
// Scoreboard bench for mbssoc_bus_timer: expected responses are queued when
// an access is driven and compared when the ack appears.
module tb_mbssoc_bus_timer;
  import mbssoc_bus_timer_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam logic [AW-1:0] BASE = 32'h0000_FF00;

  logic          clk = 1'b0;
  logic          rst;
  logic          bus_re, bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata, bus_rdata;
  logic          rdata_oe, bus_ack, irq;

  typedef struct {
    string         tag;
    logic          rd;
    logic [DW-1:0] val;
  } sb_t;

  sb_t  sb_q[$];
  sb_t  sb_mon;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ack_cnt = 0;
  int   acc_cyc = 0;
  logic irq_at_ack, irq_post_ack;

  always #5 clk = ~clk;

  mbssoc_bus_timer #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .BASE_ADDR  (BASE),
    .PRESCALE   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_re    (bus_re),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .rdata_oe  (rdata_oe),
    .bus_ack   (bus_ack),
    .irq       (irq)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus_ack) begin
      ack_cnt++;
      if (sb_q.size() == 0) begin
        check("sb_underflow", DW'(sb_q.size()), 1);
      end else begin
        sb_mon = sb_q.pop_front();
        check({sb_mon.tag, "_oe"}, DW'(rdata_oe), DW'(sb_mon.rd));
        if (sb_mon.rd) check(sb_mon.tag, bus_rdata, sb_mon.val);
      end
    end
  end

  // Called just after a rising edge; accept happens on the next edge.
  task automatic access(input logic rd, input logic [1:0] off, input logic [DW-1:0] wd,
                        input logic [DW-1:0] expv, input string tag);
    sb_t e;
    int  lat;
    e.tag = tag; e.rd = rd; e.val = expv;
    sb_q.push_back(e);
    bus_re = rd; bus_we = !rd; bus_addr = BASE | AW'(off); bus_wdata = wd;
    lat = 99;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (bus_ack) begin
        lat = i;
        break;
      end
    end
    check({tag, "_lat"}, DW'(lat), 2);
    acc_cyc    = cyc;
    irq_at_ack = irq;
    @(posedge clk); #1;
    irq_post_ack = irq;
    bus_re = 1'b0; bus_we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic rd_reg(input logic [1:0] off, input logic [DW-1:0] expv, input string tag);
    access(1'b1, off, '0, expv, tag);
  endtask

  task automatic wr_reg(input logic [1:0] off, input logic [DW-1:0] wd, input string tag);
    access(1'b0, off, wd, '0, tag);
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic read_all_zero(input string pfx);
    rd_reg(REG_CTRL,   0, {pfx, "_ctrl"});
    rd_reg(REG_LOAD,   0, {pfx, "_load"});
    rd_reg(REG_COUNT,  0, {pfx, "_count"});
    rd_reg(REG_STATUS, 0, {pfx, "_status"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b, c0, k, rise;
    rst = 1'b1; bus_re = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", DW'(bus_ack), 0);
    check("rst_oe", DW'(rdata_oe), 0);
    check("rst_irq", DW'(irq), 0);
    check("rst_rdata", bus_rdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    read_all_zero("init");

    // Auto-reload with interrupt enabled.
    wr_reg(REG_LOAD, 5, "ar_wload");
    wr_reg(REG_CTRL, 7, "ar_wctrl");
    a = acc_cyc;
    rise = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (irq) begin
        rise = cyc;
        break;
      end
    end
    check("ar_irq_delay", DW'(rise - a), 25);
    @(posedge clk); #1;
    k = (cyc - a) / 4;
    rd_reg(REG_COUNT, DW'(5 - (k % 6)), "ar_count");
    rd_reg(REG_STATUS, 1, "ar_status");

    // Clear landing on the expiry edge loses to the set.
    wait_until(a + 47);
    wr_reg(REG_STATUS, 1, "w1c_same");
    rd_reg(REG_STATUS, 1, "w1c_same_status");
    wr_reg(REG_STATUS, 1, "w1c_late");
    check("w1c_irq_at_ack", DW'(irq_at_ack), 1);
    check("w1c_irq_drop", DW'(irq_post_ack), 0);
    rd_reg(REG_STATUS, 0, "w1c_late_status");
    wr_reg(REG_CTRL, 0, "ar_stop");

    // One-shot, interrupt disabled.
    wr_reg(REG_STATUS, 1, "os_clr");
    wr_reg(REG_LOAD, 2, "os_wload");
    wr_reg(REG_CTRL, 1, "os_wctrl");
    b = acc_cyc;
    wait_until(b + 11);
    rd_reg(REG_STATUS, 0, "os_status_pre");
    rd_reg(REG_STATUS, 1, "os_status_post");
    rd_reg(REG_CTRL, 0, "os_ctrl_en");
    rd_reg(REG_COUNT, 0, "os_count");
    check("os_irq", DW'(irq), 0);
    wait_until(b + 40);
    rd_reg(REG_COUNT, 0, "os_count_hold");
    wr_reg(REG_CTRL, 32'hFFFF_FFF0, "ctrl_hi");
    rd_reg(REG_CTRL, 0, "ctrl_hi_rd");

    // Held read strobe acks once.
    wr_reg(REG_LOAD, 32'h0000_A5A5, "held_wload");
    begin
      sb_t e;
      e.tag = "held_rd"; e.rd = 1'b1; e.val = 32'h0000_A5A5;
      sb_q.push_back(e);
    end
    c0 = ack_cnt;
    bus_re = 1'b1; bus_addr = BASE | AW'(REG_LOAD);
    repeat (5) @(posedge clk);
    #1 bus_re = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("held_acks", DW'(ack_cnt - c0), 1);

    // Misses and the both-strobes error leave everything untouched.
    c0 = ack_cnt;
    bus_we = 1'b1; bus_addr = BASE + 32'h4 + 32'h1; bus_wdata = 32'h77;
    repeat (3) @(posedge clk);
    #1 bus_we = 1'b0; bus_re = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus_re = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("miss_acks", DW'(ack_cnt - c0), 0);
    c0 = ack_cnt;
    bus_re = 1'b1; bus_we = 1'b1; bus_addr = BASE | AW'(REG_LOAD); bus_wdata = 32'h99;
    repeat (3) @(posedge clk);
    #1 bus_re = 1'b0; bus_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("both_acks", DW'(ack_cnt - c0), 0);
    rd_reg(REG_LOAD, 32'h0000_A5A5, "load_intact");

    // Reset while the response is pending.
    wr_reg(REG_CTRL, 6, "rst_wctrl");
    c0 = ack_cnt;
    bus_re = 1'b1; bus_addr = BASE | AW'(REG_LOAD);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; bus_re = 1'b0;
    check("rst_mid_acks", DW'(ack_cnt - c0), 0);
    read_all_zero("post_rst");
    check("post_rst_irq", DW'(irq), 0);

    repeat (2) @(posedge clk);
    check("sb_leftover", DW'(sb_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
